sseg_scan_mux: RTL

- Consumer end of the six-digit seven-segment pattern bus (in0..in5, each {DP, g..a}, active low) driven by the display-effect generators.
- Time-multiplexes the six patterns onto one shared segment bus and six active-low anode lines.
- Adds a per-slot ghost-suppression blanking interval and 4-bit PWM brightness control.
- Snapshots all six inputs once per frame so a mid-frame pattern change never tears the display.

---
 rtl/sseg_scan_mux.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: six-digit seven-segment scan multiplexer.
// Patterns are snapshotted once per frame, then shown one digit per slot.
// Each slot opens with an optional all-dark blanking window that
// suppresses ghosting, and the lit phase is gated by a 4-bit PWM
// brightness control.
// Segments and anodes are active low. All outputs are registered and
// show the internal state of the previous cycle.
module sseg_scan_mux #(
  parameter int REFRESH_COUNT = 50_000,
  parameter int BLANK_CYCLES  = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] duty,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  output logic [7:0] sseg,
  output logic [5:0] an,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);

  localparam logic [23:0] CNT_LAST  = 24'(REFRESH_COUNT - 1);
  localparam logic [23:0] BLANK_END = 24'(BLANK_CYCLES);
  localparam logic [2:0]  SLOT_LAST = 3'd5;

  logic [23:0] cnt;
  logic [2:0]  slot;
  logic [3:0]  pwm;
  logic [7:0]  snap [6];
  logic        load_pending;

  logic        slot_end;
  logic        frame_end;
  logic        capture;
  logic        in_blank;
  logic        gate_open;
  logic        lit;
  logic [7:0]  seg_sel;
  logic [5:0]  an_sel;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (slot == SLOT_LAST);
  // The first enabled cycle after reset captures straight away, so no
  // blank frame follows reset.
  assign capture   = en && (load_pending || frame_end);

  // With no blanking configured, the compare is left out entirely rather
  // than comparing against zero.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < BLANK_END);
    end
  endgenerate

  assign gate_open = (duty == 4'hF) || (pwm < duty);
  assign lit       = en && !in_blank && gate_open;

  // Select the snapshot pattern and the active-low anode for the current slot.
  always_comb begin
    seg_sel = 8'hFF;
    an_sel  = 6'h3F;
    case (slot)
      3'd0: begin seg_sel = snap[0]; an_sel = 6'b111110; end
      3'd1: begin seg_sel = snap[1]; an_sel = 6'b111101; end
      3'd2: begin seg_sel = snap[2]; an_sel = 6'b111011; end
      3'd3: begin seg_sel = snap[3]; an_sel = 6'b110111; end
      3'd4: begin seg_sel = snap[4]; an_sel = 6'b101111; end
      3'd5: begin seg_sel = snap[5]; an_sel = 6'b011111; end
      default: begin seg_sel = 8'hFF; an_sel = 6'h3F; end
    endcase
  end

  // Slot timer, slot index and PWM phase. All of them hold while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      slot <= '0;
      pwm  <= '0;
    end else if (en) begin
      if (slot_end) begin
        cnt  <= '0;
        slot <= (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
        pwm  <= '0;
      end else begin
        cnt <= cnt + 24'd1;
        if (!in_blank) begin
          pwm <= pwm + 4'd1;
        end
      end
    end
  end

  // Frame snapshot of all six patterns. It is taken on the same edge that
  // wraps from slot 5 to slot 0, so slot 0 already shows the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) begin
        snap[k] <= 8'hFF;
      end
      load_pending <= 1'b1;
    end else if (capture) begin
      snap[0]      <= in0;
      snap[1]      <= in1;
      snap[2]      <= in2;
      snap[3]      <= in3;
      snap[4]      <= in4;
      snap[5]      <= in5;
      load_pending <= 1'b0;
    end
  end

  // Registered outputs. Anode and segments are loaded on the same edge, so a
  // digit is never lit with its neighbour's pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg       <= 8'hFF;
      an         <= 6'h3F;
      digit_idx  <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= capture;
      digit_idx  <= slot;
      if (lit) begin
        sseg <= seg_sel;
        an   <= an_sel;
      end else begin
        sseg <= 8'hFF;
        an   <= 6'h3F;
      end
    end
  end

endmodule
